ifetch_queue: RTL and testbench

//  Instruction fetch front end feeding the 16-bit instruction decoder. Fetches

---
 rtl/ifetch_queue.sv | 197 +++++++++++++++++++
 tb/tb_ifetch_queue.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch queue feeding the 16-bit decoder
//
// Purpose: fetches aligned 32-bit words from the instruction bus, splits each
// word into two 16-bit instructions (low halfword first), buffers them in a
// halfword FIFO and offers the head instruction to the decoder every cycle.
// A redirect flushes the FIFO and restarts fetch at the new halfword PC.
//
// Ports:
//   clk          in   1    clock
//   reset        in   1    asynchronous, active-high reset
//   mem_req      out  1    fetch request, held until mem_ack
//   mem_addr     out  RV   word address of the fetch, stable while mem_req
//   mem_ack      in   1    one-cycle completion pulse, mem_rdata valid
//   mem_rdata    in   32   fetched word, [15:0] at addr, [31:16] at addr+2
//   dec_ready    in   1    decoder accepts an instruction this cycle
//   redirect     in   1    flush queue and restart fetch at redirect_pc
//   redirect_pc  in   RV   new PC, bit 0 ignored
//   ins          out  16   instruction at the FIFO head (0 when empty)
//   ins_pc       out  RV   address of ins
//   idone        out  1    ins valid and taken by the decoder this cycle
module ifetch_queue #(
   parameter int             RV       = 32,
   parameter int             DEPTH    = 4,
   parameter logic [RV-1:0]  RESET_PC = '0
) (
   input  logic          clk,
   input  logic          reset,
   output logic          mem_req,
   output logic [RV-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [31:0]   mem_rdata,
   input  logic          dec_ready,
   input  logic          redirect,
   input  logic [RV-1:0] redirect_pc,
   output logic [15:0]   ins,
   output logic [RV-1:0] ins_pc,
   output logic          idone
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [RV-1:0] r_addr;
   logic [RV-1:0] w_addr_nxt;
   logic [RV-1:0] r_pend_addr;
   logic [RV-1:0] w_pend_nxt;
   logic          r_skip_low;
   logic          w_skip_nxt;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [RV-1:0] r_ins_pc;
   logic [15:0]   r_mem [DEPTH];

   logic          w_empty;
   logic [CW-1:0] w_free;
   logic          w_can_fetch;
   logic          w_push;
   logic [CW-1:0] w_push_n;
   logic          w_pop;
   logic [RV-1:0] w_redir_word;
   logic [RV-1:0] w_redir_half;

   assign w_redir_word = redirect_pc & ~RV'(3);
   assign w_redir_half = redirect_pc & ~RV'(1);

   assign w_empty     = (r_count == '0);
   assign w_free      = DEPTH_C - r_count;
   // Two free slots are always reserved before fetching, so a full word can
   // land even when skip_low is clear; the FIFO therefore never overflows.
   assign w_can_fetch = (w_free >= CW'(2));

   // Data is kept only for an ack in WAIT that is not cancelled by a
   // same-cycle redirect; acks in IDLE (stale) and DROP are discarded.
   assign w_push   = (r_state == S_WAIT) && mem_ack && !redirect;
   assign w_push_n = !w_push ? '0 : (r_skip_low ? CW'(1) : CW'(2));

   assign idone  = !w_empty && dec_ready && !redirect;
   assign w_pop  = idone;
   assign ins    = w_empty ? 16'h0000 : r_mem[r_rd_ptr];
   assign ins_pc = r_ins_pc;

   // FSM next-state and request outputs
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_pend_nxt  = r_pend_addr;
      w_skip_nxt  = r_skip_low;
      mem_req     = (r_state != S_IDLE);
      mem_addr    = r_addr;

      if (redirect) begin
         w_skip_nxt = redirect_pc[1];
      end

      case (r_state)
         S_IDLE: begin
            if (redirect) begin
               w_addr_nxt = w_redir_word;
            end else if (w_can_fetch) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_ack) begin
               w_state_nxt = S_IDLE;
               if (redirect) begin
                  w_addr_nxt = w_redir_word;
               end else begin
                  w_addr_nxt = r_addr + RV'(4);
                  w_skip_nxt = 1'b0;
               end
            end else if (redirect) begin
               // mem_addr must stay put while the request is outstanding,
               // so the redirect target is parked until the ack arrives.
               w_state_nxt = S_DROP;
               w_pend_nxt  = w_redir_word;
            end
         end
         S_DROP: begin
            if (mem_ack) begin
               w_state_nxt = S_IDLE;
               w_addr_nxt  = redirect ? w_redir_word : r_pend_addr;
            end else if (redirect) begin
               w_pend_nxt = w_redir_word;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // FIFO occupancy: redirect flushes and wins over any push or pop
   always_comb begin
      w_count_nxt = r_count;
      if (redirect) begin
         w_count_nxt = '0;
      end else begin
         w_count_nxt = r_count + w_push_n - {{(CW-1){1'b0}}, w_pop};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_addr      <= RESET_PC & ~RV'(3);
         r_pend_addr <= RESET_PC & ~RV'(3);
         r_skip_low  <= RESET_PC[1];
         r_count     <= '0;
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_ins_pc    <= RESET_PC & ~RV'(1);
      end else begin
         r_state     <= w_state_nxt;
         r_addr      <= w_addr_nxt;
         r_pend_addr <= w_pend_nxt;
         r_skip_low  <= w_skip_nxt;
         r_count     <= w_count_nxt;
         if (redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_ins_pc <= w_redir_half;
         end else begin
            r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, w_pop};
            r_wr_ptr <= r_wr_ptr + w_push_n[PW-1:0];
            if (w_pop) begin
               r_ins_pc <= r_ins_pc + RV'(2);
            end
         end
      end
   end

   // Halfword storage; contents are only observed through the count, so
   // the array needs no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         if (r_skip_low) begin
            r_mem[r_wr_ptr] <= mem_rdata[31:16];
         end else begin
            r_mem[r_wr_ptr]            <= mem_rdata[15:0];
            r_mem[r_wr_ptr + PW'(1)]   <= mem_rdata[31:16];
         end
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed bench for ifetch_queue
module tb_ifetch_queue;

   localparam int RV = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          mem_req;
   logic [RV-1:0] mem_addr;
   logic          mem_ack;
   logic [31:0]   mem_rdata;
   logic          dec_ready;
   logic          redirect;
   logic [RV-1:0] redirect_pc;
   logic [15:0]   ins;
   logic [RV-1:0] ins_pc;
   logic          idone;

   int n_checks = 0;
   int n_fail   = 0;

   bit resp_en;
   int ack_dly;
   int resp_cnt;

   logic [15:0] q_ins[$];
   logic [31:0] q_pc[$];

   always #5 clk = ~clk;

   ifetch_queue #(.RV(RV), .DEPTH(4), .RESET_PC('0)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .dec_ready   (dec_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .ins         (ins),
      .ins_pc      (ins_pc),
      .idone       (idone)
   );

   function automatic logic [31:0] word_at(input logic [31:0] a);
      logic [15:0] lo;
      logic [15:0] hi;
      case (a)
         32'h0000_0000: return 32'h2222_1111;
         32'h0000_0004: return 32'h4444_3333;
         32'h0000_0100: return 32'hBBBB_AAAA;
         default: begin
            lo = 16'h5000 + a[15:0];
            hi = lo + 16'h0002;
            return {hi, lo};
         end
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Record every instruction taken by the decoder, sampled mid-cycle.
   always @(negedge clk) begin
      #3;
      if (!reset && idone) begin
         q_ins.push_back(ins);
         q_pc.push_back(ins_pc);
      end
   end

   // Advance to the next negedge and run the memory responder.
   task automatic tick();
      @(negedge clk);
      mem_ack = 1'b0;
      if (resp_en && mem_req) begin
         resp_cnt++;
         if (resp_cnt >= ack_dly) begin
            mem_ack   = 1'b1;
            mem_rdata = word_at(mem_addr);
            resp_cnt  = 0;
         end
      end else begin
         resp_cnt = 0;
      end
   endtask

   task automatic clear_q();
      q_ins.delete();
      q_pc.delete();
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      redirect  = 1'b0;
      dec_ready = 1'b0;
      resp_en   = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      clear_q();
   endtask

   task automatic wait_ins(input string tag, input int n, input int budget);
      int k = 0;
      while (q_ins.size() < n && k < budget) begin
         tick();
         k++;
      end
      check(tag, 32'(q_ins.size() >= n), 32'd1);
   endtask

   task automatic wait_req(input string tag, input int budget);
      int k = 0;
      while (!mem_req && k < budget) begin
         tick();
         k++;
      end
      check(tag, 32'(mem_req), 32'd1);
   endtask

   task automatic check_ins(input string tag, input int idx, input logic [15:0] e_ins,
                            input logic [31:0] e_pc);
      logic [15:0] o_ins;
      logic [31:0] o_pc;
      o_ins = 'x;
      o_pc  = 'x;
      if (idx < q_ins.size()) begin
         o_ins = q_ins[idx];
         o_pc  = q_pc[idx];
      end
      check({tag, "_ins"}, {16'h0, o_ins}, {16'h0, e_ins});
      check({tag, "_pc"}, o_pc, e_pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset       = 1'b1;
      dec_ready   = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      mem_ack     = 1'b0;
      mem_rdata   = '0;
      resp_en     = 1'b0;
      ack_dly     = 1;
      resp_cnt    = 0;

      // Reset state
      repeat (3) tick();
      #1;
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_idone", 32'(idone), 32'd0);
      check("rst_ins", 32'(ins), 32'h0);
      check("rst_ins_pc", ins_pc, 32'h0);

      // 1: straight-line fetch from RESET_PC
      tick();
      reset     = 1'b0;
      dec_ready = 1'b1;
      resp_en   = 1'b1;
      ack_dly   = 1;
      clear_q();
      wait_ins("t1_wait", 4, 40);
      check_ins("t1_0", 0, 16'h1111, 32'h0);
      check_ins("t1_1", 1, 16'h2222, 32'h2);
      check_ins("t1_2", 2, 16'h3333, 32'h4);
      check_ins("t1_3", 3, 16'h4444, 32'h6);

      // 2: full FIFO stalls fetch; two pops release it
      do_reset();
      resp_en = 1'b1;
      ack_dly = 1;
      repeat (12) tick();
      #1;
      check("t2_full_req", 32'(mem_req), 32'd0);
      check("t2_full_addr", mem_addr, 32'h8);
      check("t2_full_ins", 32'(ins), 32'h1111);
      check("t2_full_idone", 32'(idone), 32'd0);
      resp_en = 1'b0;
      tick();
      dec_ready = 1'b1;
      tick();
      tick();
      dec_ready = 1'b0;
      #1;
      check("t2_after2_req", 32'(mem_req), 32'd0);
      wait_req("t2_req", 6);
      check("t2_req_addr", mem_addr, 32'h8);
      check("t2_popped", 32'(q_ins.size()), 32'd2);
      check_ins("t2_0", 0, 16'h1111, 32'h0);
      check_ins("t2_1", 1, 16'h2222, 32'h2);

      // 3: redirect to an odd halfword with three entries queued
      do_reset();
      resp_en = 1'b1;
      ack_dly = 1;
      repeat (10) tick();
      resp_en = 1'b0;
      tick();
      dec_ready = 1'b1;
      tick();
      clear_q();
      redirect    = 1'b1;
      redirect_pc = 32'h102;
      #1;
      check("t3_idone_redir", 32'(idone), 32'd0);
      tick();
      redirect = 1'b0;
      resp_en  = 1'b1;
      #1;
      check("t3_pc_load", ins_pc, 32'h102);
      wait_ins("t3_wait", 2, 30);
      check_ins("t3_0", 0, 16'hBBBB, 32'h102);
      check_ins("t3_1", 1, 16'h5104, 32'h104);

      // 4: redirect while a slow request is outstanding
      do_reset();
      dec_ready = 1'b1;
      resp_en   = 1'b1;
      ack_dly   = 3;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (mem_req && mem_addr == 32'h10) break;
      end
      check("t4_reach10", mem_addr, 32'h10);
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      tick();
      clear_q();
      redirect = 1'b0;
      #1;
      check("t4_drop_req", 32'(mem_req), 32'd1);
      check("t4_drop_addr", mem_addr, 32'h10);
      tick();
      #1;
      check("t4_ack_addr", mem_addr, 32'h10);
      check("t4_ack_seen", 32'(mem_ack), 32'd1);
      tick();
      #1;
      check("t4_idle_req", 32'(mem_req), 32'd0);
      check("t4_next_addr", mem_addr, 32'h200);
      wait_ins("t4_wait", 1, 30);
      check_ins("t4_0", 0, 16'h5200, 32'h200);

      // 5: ack in the same cycle as a redirect is discarded
      do_reset();
      dec_ready = 1'b1;
      resp_en   = 1'b1;
      ack_dly   = 1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (mem_ack) break;
      end
      redirect    = 1'b1;
      redirect_pc = 32'h300;
      clear_q();
      tick();
      redirect = 1'b0;
      #1;
      check("t5_req_low", 32'(mem_req), 32'd0);
      check("t5_addr", mem_addr, 32'h300);
      wait_ins("t5_wait", 1, 20);
      check_ins("t5_0", 0, 16'h5300, 32'h300);

      // 6: reset mid-request, then a stray ack after release
      do_reset();
      dec_ready = 1'b1;
      repeat (3) tick();
      #1;
      check("t6_req_up", 32'(mem_req), 32'd1);
      reset = 1'b1;
      #1;
      check("t6_async_drop", 32'(mem_req), 32'd0);
      tick();
      tick();
      reset     = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      resp_en   = 1'b1;
      clear_q();
      wait_ins("t6_wait", 2, 20);
      check_ins("t6_0", 0, 16'h1111, 32'h0);
      check_ins("t6_1", 1, 16'h2222, 32'h2);

      // 7: address wrap past the top of the address space
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      clear_q();
      tick();
      redirect = 1'b0;
      wait_ins("t7_wait", 4, 40);
      check_ins("t7_0", 0, 16'h4FFC, 32'hFFFF_FFFC);
      check_ins("t7_1", 1, 16'h4FFE, 32'hFFFF_FFFE);
      check_ins("t7_2", 2, 16'h1111, 32'h0);
      check_ins("t7_3", 3, 16'h2222, 32'h2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
